// File: rtl/prng_seq_gen.sv
// Fibonacci-LFSR pseudo-random sequence generator with hold, free-run,
// single-step and counted-burst modes, seed load, lock-up recovery and wrap flag.
module prng_seq_gen #(
  parameter int                WIDTH        = 4,
  parameter logic [WIDTH-1:0]  TAPS         = 4'b1100,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = 4'b0001,
  parameter int                CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // An all-zero state would lock the LFSR forever, so it restarts from the seed.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] nxt;
    if (cur == '0) nxt = DEFAULT_SEED;
    else           nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
    return nxt;
  endfunction

  function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             adv;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] ref_q;

  assign q_nxt = lfsr_next(q);
  assign busy  = (state == BURST);

  always_comb begin
    adv = 1'b0;
    if (!load) begin
      case (mode)
        2'b01:   adv = 1'b1;
        2'b10:   adv = step;
        2'b11:   adv = (state == BURST);
        default: adv = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (load) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (mode == 2'b11 && step) begin
            if (burst_len != '0) begin
              state_nxt = BURST;
              cnt_nxt   = burst_len;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        BURST: begin
          // Leaving burst mode abandons the burst without a completion pulse.
          if (mode != 2'b11) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= DEFAULT_SEED;
      ref_q <= DEFAULT_SEED;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      q     <= seed_fix(seed);
      ref_q <= seed_fix(seed);
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      valid <= adv;
      wrap  <= adv && (q_nxt == ref_q);
      if (adv) q <= q_nxt;
    end
  end

endmodule

// File: tb/tb_prng_seq_gen.sv
// Scoreboard bench for prng_seq_gen: stimulus queues expected output events,
// a negedge monitor pops and compares them whenever valid or done is seen.
module tb_prng_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       step;
  logic       load;
  logic [3:0] seed;
  logic [7:0] burst_len;
  logic [3:0] q;
  logic       valid, wrap, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [3:0] q;
    logic       w;
    logic       d;
  } exp_t;

  exp_t sb[$];

  // Period of x^4+x^3+1 starting after 1: 2,4,9,3,6,D,A,5,B,7,F,E,C,8,1
  logic [3:0] per [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                           4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

  prng_seq_gen dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .step      (step),
    .load      (load),
    .seed      (seed),
    .burst_len (burst_len),
    .q         (q),
    .valid     (valid),
    .wrap      (wrap),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic v, input logic [3:0] qv, input logic w, input logic d);
    exp_t e;
    e.v = v; e.q = qv; e.w = w; e.d = d;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (valid || done)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: valid=%b q=%h wrap=%b done=%b at %0t",
                   valid, q, wrap, done, $time);
        end else begin
          e = sb.pop_front();
          if (valid !== e.v || q !== e.q || wrap !== e.w || done !== e.d) begin
            errors++;
            $display("FAIL event: got valid=%b q=%h wrap=%b done=%b expected valid=%b q=%h wrap=%b done=%b at %0t",
                     valid, q, wrap, done, e.v, e.q, e.w, e.d, $time);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    rst = 1'b0; mode = 2'b00; step = 1'b0; load = 1'b0; seed = 4'h0; burst_len = 8'd0;
    #12;
    chk("rst_q", q, 4'h1);
    chk("rst_valid", valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    tick();

    // Free-run through one full period back to 1
    for (int i = 0; i < 15; i++) push(1'b1, per[i], i == 14, 1'b0);
    mode = 2'b01;
    repeat (15) tick();
    mode = 2'b00;
    repeat (2) tick();
    chk("freerun_end_q", q, 4'h1);

    // Single-step: three pulses separated by idle cycles
    mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      push(1'b1, per[i], 1'b0, 1'b0);
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (5) tick();
      chk("step_hold_q", q, per[i]);
    end
    mode = 2'b00;

    // Seed load: zero seed maps to default, then seed 6
    load = 1'b1; seed = 4'h0;
    tick();
    load = 1'b0;
    chk("load0_q", q, 4'h1);
    load = 1'b1; seed = 4'h6;
    tick();
    load = 1'b0;
    chk("load6_q", q, 4'h6);
    for (int i = 0; i < 15; i++) push(1'b1, per[(5 + i) % 15], i == 14, 1'b0);
    mode = 2'b01;
    repeat (15) tick();
    mode = 2'b00;
    tick();
    chk("load6_wrap_q", q, 4'h6);

    // Burst of 4 from q=1
    load = 1'b1; seed = 4'h1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b1, per[i], 1'b0, i == 3);
    mode = 2'b11; burst_len = 8'd4; step = 1'b1;
    tick();
    step = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_cnt++;
      tick();
    end
    chk("burst4_busy_cycles", busy_cnt, 4);
    chk("burst4_busy_end", busy, 0);
    repeat (3) tick();
    chk("burst4_hold_q", q, 4'h3);

    // Zero-length burst: done only
    push(1'b0, 4'h3, 1'b0, 1'b1);
    burst_len = 8'd0; step = 1'b1;
    tick();
    step = 1'b0;
    chk("burst0_busy", busy, 0);
    repeat (3) tick();
    chk("burst0_q", q, 4'h3);

    // Burst of 10 aborted by load after three advances
    for (int i = 0; i < 3; i++) push(1'b1, per[4 + i], 1'b0, 1'b0);
    burst_len = 8'd10; step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    load = 1'b1; seed = 4'h5;
    tick();
    load = 1'b0;
    chk("abort_load_q", q, 4'h5);
    chk("abort_load_busy", busy, 0);
    repeat (4) tick();
    chk("abort_load_hold_q", q, 4'h5);

    // Burst of 10 aborted by asynchronous reset after three advances
    for (int i = 0; i < 3; i++) push(1'b1, per[8 + i], 1'b0, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    chk("pre_reset_busy", busy, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_q", q, 4'h1);
    chk("async_rst_valid", valid, 0);
    chk("async_rst_wrap", wrap, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    mode = 2'b00;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("post_reset_q", q, 4'h1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
